neuron_mac_sequencer: RTL and testbench
=======================================

// Module: neuron_mac_sequencer
// PURPOSE
//  Downstream consumer of one per-neuron weight BRAM in the ANN layer. Walks BRAM addresses
//  0..N_INPUTS-1 in read-only mode (write-enable tied low) and accepts one activation per address
//  over a valid/ready stream. Accumulates activation*weight products and adds BIAS.
//  Emits one saturated fixed-point neuron output over a valid/ready handshake.
// PARAMETERS
//  N_INPUTS  28  weights/activations per neuron (BRAM depth)
//  ADDR_W    5   BRAM address width, >= clog2(N_INPUTS)
//  DATA_W    16  signed two's-complement width of weights, activations, bias and output
//  FRAC_BITS 8   fractional bits, Q(DATA_W-FRAC_BITS).FRAC_BITS
//  ACC_W     40  accumulator width, >= 2*DATA_W + clog2(N_INPUTS) + 1
// PORTS
//  CLK        in  1       single clock; all state on posedge (BRAM reads on negedge)
//  RST        in  1       asynchronous, active-high reset
//  START      in  1       1-cycle pulse; begins a neuron evaluation when idle
//  BIAS       in  DATA_W  signed bias, sampled on the START cycle
//  W_ADDR     out ADDR_W  weight BRAM address
//  W_EN       out 1       weight BRAM enable
//  W_WE       out 1       weight BRAM write enable, constant 0
//  W_DO       in  DATA_W  weight BRAM read data
//  IN_DATA    in  DATA_W  signed activation
//  IN_VALID   in  1       activation valid
//  IN_READY   out 1       activation accepted when IN_VALID & IN_READY
//  OUT_DATA   out DATA_W  saturated neuron result
//  OUT_VALID  out 1       result valid; held until OUT_READY
//  OUT_READY  in  1       downstream accepts result
//  BUSY       out 1       high in every state except IDLE
// BEHAVIOUR
//  - Reset values: W_ADDR=0, W_EN=0, IN_READY=0, OUT_DATA=0, OUT_VALID=0, BUSY=0.
//    Accumulator and counter are cleared. FSM goes to IDLE. A mid-evaluation reset aborts the
//    evaluation; no output is produced.
//  - States: IDLE -> (START) RUN -> (last beat) FINISH -> OUT -> (OUT_READY) IDLE.
//  - IDLE: on START, acc <= sign-extended BIAS << FRAC_BITS. Also k <= 0, W_ADDR <= 0,
//    W_EN <= 1. START outside IDLE is ignored.
//  - RUN:
//    - IN_READY = 1. Because the BRAM reads on negedge, W_DO holds W[W_ADDR] at every RUN posedge.
//      This gives zero-bubble streaming: one beat per cycle.
//    - On a beat: acc += sext(IN_DATA*W_DO), with the full 2*DATA_W signed product.
//      Then k++ and W_ADDR <= k+1.
//    - With no beat (IN_VALID=0), k, W_ADDR and acc hold.
//    - The beat at k = N_INPUTS-1 moves to FINISH. W_EN <= 0, IN_READY drops next cycle,
//      and W_ADDR returns to 0.
//  - FINISH (1 cycle):
//    - r = acc >>> FRAC_BITS (arithmetic shift, floor).
//    - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//    - Register the result into OUT_DATA, set OUT_VALID=1, go to OUT.
//  - OUT: OUT_DATA and OUT_VALID are stable until OUT_READY. Acceptance clears OUT_VALID and
//    returns to IDLE. START in that same cycle is ignored.
//  - Latency: START to first IN_READY is 1 cycle. Last beat to OUT_VALID is 2 cycles.
//  - Overflow never wraps inside ACC_W given the parameter constraint. Saturation is applied only
//    at the output.
// CONFIGURATION
//  - NEURON_RELU_EN defined: FINISH clamps negative results to 0 (ReLU after saturation).
//  - NEURON_RELU_EN undefined: the signed saturated result passes through unchanged.
// STRUCTURE
//  - Shared package ann_pkg holds:
//    - the FSM state encoding (IDLE/RUN/FINISH/OUT);
//    - DATA_W/FRAC_BITS defaults;
//    - the Q-format saturation limits SAT_MAX=16'h7FFF and SAT_MIN=16'h8000.
//  - One sub-module, ann_saturate: combinational shift, saturate and optional ReLU from ACC_W to
//    DATA_W. It is reused by later layers.
// TESTING
//  1. All W=0x0100, all X=0x0100 streamed back-to-back, BIAS=0 -> OUT_DATA=0x1C00 (28.0).
//     OUT_VALID follows the last beat by 2 cycles.
//  2. Same as 1 with IN_VALID toggled 1/0 every cycle -> same 0x1C00. W_ADDR holds during gaps.
//     Exactly 28 beats are consumed.
//  3. All W=0x7FFF, X=0x7FFF -> OUT_DATA=0x7FFF (saturated high).
//     All W=0x8000, X=0x7FFF -> 0x8000 without NEURON_RELU_EN, 0x0000 with it.
//  4. W=0xFF00 (-1.0), X=0x0100, BIAS=0x0200 -> -26.0 = 0xE600 without ReLU, 0x0000 with ReLU.
//  5. OUT_READY held low for 5 cycles -> OUT_DATA and OUT_VALID stable. A START during OUT is
//     ignored. Acceptance returns BUSY=0.
//  6. RST asserted after beat 10 -> all outputs at reset values immediately.
//     A fresh START then yields the correct result from test 1.

Source files
------------

// File: rtl/ann_pkg.sv
// Shared ANN layer definitions: FSM state encoding, Q-format defaults and
// saturation limits used by neuron sequencers and later layers.
package ann_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;

  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2,
    ST_OUT    = 2'd3
  } nstate_e;

endpackage

// File: rtl/neuron_mac_sequencer_if.sv
// Bundle of the neuron sequencer's control, weight-BRAM, activation-stream and
// result-stream signals; the sequencer uses the slave modport.
interface neuron_mac_sequencer_if #(
  parameter int ADDR_W = 5
);
  localparam int DW = ann_pkg::DATA_W;

  logic          start;
  logic [DW-1:0] bias;
  logic [ADDR_W-1:0] w_addr;
  logic          w_en;
  logic          w_we;
  logic [DW-1:0] w_do;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  modport master (
    output start, bias, w_do, in_data, in_valid, out_ready,
    input  w_addr, w_en, w_we, in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  start, bias, w_do, in_data, in_valid, out_ready,
    output w_addr, w_en, w_we, in_ready, out_data, out_valid, busy
  );
endinterface

// File: rtl/ann_saturate.sv
// Accumulator to DATA_W conversion: arithmetic shift (floor), saturation and,
// when NEURON_RELU_EN is defined, a ReLU clamp applied after saturation.
module ann_saturate
  import ann_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int SHIFT = 8
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [DATA_W-1:0] res_o
);

  localparam logic signed [ACC_W-1:0] HI_EXT =
    {{(ACC_W-DATA_W){SAT_MAX[DATA_W-1]}}, SAT_MAX};
  localparam logic signed [ACC_W-1:0] LO_EXT =
    {{(ACC_W-DATA_W){SAT_MIN[DATA_W-1]}}, SAT_MIN};

  logic signed [ACC_W-1:0] shifted_s;
  logic        [DATA_W-1:0] sat_s;

  always_comb begin
    shifted_s = acc_i >>> SHIFT;
    if (shifted_s > HI_EXT) begin
      sat_s = SAT_MAX;
    end else if (shifted_s < LO_EXT) begin
      sat_s = SAT_MIN;
    end else begin
      sat_s = shifted_s[DATA_W-1:0];
    end
`ifdef NEURON_RELU_EN
    if (sat_s[DATA_W-1]) begin
      res_o = {DATA_W{1'b0}};
    end else begin
      res_o = sat_s;
    end
`else
    res_o = sat_s;
`endif
  end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Per-neuron MAC sequencer: streams N_INPUTS activations against a read-only
// weight BRAM, adds the bias and emits one saturated result (ReLU via NEURON_RELU_EN).
module neuron_mac_sequencer
  import ann_pkg::*;
#(
  parameter int N_INPUTS = 28,
  parameter int ADDR_W   = 5,
  parameter int ACC_W    = 40
) (
  input logic clk,
  input logic rst,
  neuron_mac_sequencer_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(N_INPUTS - 1);

  nstate_e                  state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0]        k_q, k_d;
  logic [ADDR_W-1:0]        w_addr_q, w_addr_d;
  logic                     w_en_q, w_en_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        sat_s;
  logic signed [2*DATA_W-1:0] prod_s;
  logic                     beat_s;

  assign prod_s = $signed(bus.in_data) * $signed(bus.w_do);
  assign beat_s = (state_q == ST_RUN) && bus.in_valid;

  ann_saturate #(
    .ACC_W (ACC_W),
    .SHIFT (FRAC_BITS)
  ) u_sat (
    .acc_i (acc_q),
    .res_o (sat_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= {ACC_W{1'b0}};
      k_q         <= {ADDR_W{1'b0}};
      w_addr_q    <= {ADDR_W{1'b0}};
      w_en_q      <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      w_addr_q    <= w_addr_d;
      w_en_q      <= w_en_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    k_d         = k_q;
    w_addr_d    = w_addr_q;
    w_en_d      = w_en_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // Bias is aligned to the product's Q-format (2*FRAC_BITS fraction bits).
          acc_d    = {{(ACC_W-DATA_W-FRAC_BITS){bus.bias[DATA_W-1]}}, bus.bias,
                      {FRAC_BITS{1'b0}}};
          k_d      = {ADDR_W{1'b0}};
          w_addr_d = {ADDR_W{1'b0}};
          w_en_d   = 1'b1;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (beat_s) begin
          acc_d = acc_q + {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};
          if (k_q == LAST_K) begin
            k_d      = {ADDR_W{1'b0}};
            w_addr_d = {ADDR_W{1'b0}};
            w_en_d   = 1'b0;
            state_d  = ST_FINISH;
          end else begin
            k_d      = k_q + ADDR_W'(1);
            w_addr_d = k_q + ADDR_W'(1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FINISH: begin
        out_data_d  = sat_s;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.w_addr    = w_addr_q;
  assign bus.w_en      = w_en_q;
  assign bus.w_we      = 1'b0;
  assign bus.in_ready  = (state_q == ST_RUN);
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed, table-driven bench for neuron_mac_sequencer with a negedge-read
// weight BRAM model; expected results are hand-computed constants.
module tb_neuron_mac_sequencer;
  import ann_pkg::*;

  localparam int N_IN = 28;

`ifdef NEURON_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef struct {
    logic [15:0] w;
    logic [15:0] x;
    logic [15:0] bias;
    bit          ramp;
    bit          toggle;
    int          hold;
    logic [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neuron_mac_sequencer_if #(.ADDR_W(5)) ifc ();

  neuron_mac_sequencer #(
    .N_INPUTS (28),
    .ADDR_W   (5),
    .ACC_W    (40)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  logic [15:0] mem [0:31];

  always @(negedge clk) ifc.w_do <= mem[ifc.w_addr];

  int n_pass  = 0;
  int n_total = 0;
  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic load_mem(input vec_t v, output logic [15:0] xs [0:27]);
    for (int i = 0; i < N_IN; i++) begin
      mem[i] = v.ramp ? 16'(i) : v.w;
      xs[i]  = v.ramp ? 16'(i * 256) : v.x;
    end
  endtask

  task automatic run_case(input vec_t v, input int idx);
    int beats;
    int cyc;
    bit hs;
    logic [15:0] xs [0:27];
    load_mem(v, xs);
    @(posedge clk); #1;
    ifc.bias  = v.bias;
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    chk($sformatf("v%0d_ready_lat", idx), ifc.in_ready, 32'd1);
    chk($sformatf("v%0d_busy", idx), ifc.busy, 32'd1);
    chk($sformatf("v%0d_wen", idx), ifc.w_en, 32'd1);
    beats = 0;
    cyc   = 0;
    while (beats < N_IN && cyc < 200) begin
      ifc.in_valid = (v.toggle && (cyc % 2 == 1)) ? 1'b0 : 1'b1;
      ifc.in_data  = xs[beats];
      hs = ifc.in_valid && ifc.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) beats++;
      else if (!ifc.in_valid) chk($sformatf("v%0d_gap_addr", idx), ifc.w_addr, 32'(beats));
    end
    chk($sformatf("v%0d_beats", idx), beats, N_IN);
    chk($sformatf("v%0d_ready_drop", idx), ifc.in_ready, 32'd0);
    chk($sformatf("v%0d_valid_early", idx), ifc.out_valid, 32'd0);
    chk($sformatf("v%0d_addr_ret", idx), {ifc.w_en, ifc.w_addr}, 32'd0);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    chk($sformatf("v%0d_valid", idx), ifc.out_valid, 32'd1);
    chk($sformatf("v%0d_data", idx), ifc.out_data, 32'(v.exp));
    for (int h = 0; h < v.hold; h++) begin
      ifc.start = (h == 2);
      @(posedge clk); #1;
      chk($sformatf("v%0d_hold%0d_valid", idx, h), ifc.out_valid, 32'd1);
      chk($sformatf("v%0d_hold%0d_data", idx, h), ifc.out_data, 32'(v.exp));
      chk($sformatf("v%0d_hold%0d_busy", idx, h), ifc.busy, 32'd1);
    end
    ifc.out_ready = 1'b1;
    ifc.start     = (v.hold > 0);
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    ifc.start     = 1'b0;
    chk($sformatf("v%0d_accept_valid", idx), ifc.out_valid, 32'd0);
    chk($sformatf("v%0d_accept_busy", idx), ifc.busy, 32'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d_idle_busy", idx), ifc.busy, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_waddr"}, ifc.w_addr, 32'd0);
    chk({tag, "_wen"}, ifc.w_en, 32'd0);
    chk({tag, "_ready"}, ifc.in_ready, 32'd0);
    chk({tag, "_odata"}, ifc.out_data, 32'd0);
    chk({tag, "_ovalid"}, ifc.out_valid, 32'd0);
    chk({tag, "_busy"}, ifc.busy, 32'd0);
  endtask

  initial begin
    logic [15:0] xs [0:27];
    vecs[0] = '{w:16'h0100, x:16'h0100, bias:16'h0000, ramp:1'b0, toggle:1'b0, hold:0, exp:16'h1C00};
    vecs[1] = '{w:16'h0100, x:16'h0100, bias:16'h0000, ramp:1'b0, toggle:1'b1, hold:0, exp:16'h1C00};
    vecs[2] = '{w:16'h7FFF, x:16'h7FFF, bias:16'h0000, ramp:1'b0, toggle:1'b0, hold:0, exp:16'h7FFF};
    vecs[3] = '{w:16'h8000, x:16'h7FFF, bias:16'h0000, ramp:1'b0, toggle:1'b0, hold:0,
                exp:(RELU ? 16'h0000 : 16'h8000)};
    vecs[4] = '{w:16'hFF00, x:16'h0100, bias:16'h0200, ramp:1'b0, toggle:1'b0, hold:0,
                exp:(RELU ? 16'h0000 : 16'hE600)};
    vecs[5] = '{w:16'h0001, x:16'h0001, bias:16'hFFFF, ramp:1'b0, toggle:1'b0, hold:0,
                exp:(RELU ? 16'h0000 : 16'hFFFF)};
    vecs[6] = '{w:16'h0000, x:16'h0000, bias:16'h0000, ramp:1'b1, toggle:1'b1, hold:0, exp:16'h1B12};
    vecs[7] = '{w:16'h0100, x:16'h0100, bias:16'h0100, ramp:1'b0, toggle:1'b0, hold:5, exp:16'h1D00};

    for (int i = 0; i < 32; i++) mem[i] = 16'h5555;
    rst           = 1'b1;
    ifc.start     = 1'b0;
    ifc.bias      = 16'h0000;
    ifc.in_data   = 16'h0000;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst0");
    chk("rst0_we", ifc.w_we, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", ifc.busy, 32'd0);

    for (int i = 0; i < 8; i++) run_case(vecs[i], i);

    // Abort mid-evaluation after ten beats, then rerun the first vector.
    load_mem(vecs[0], xs);
    ifc.bias  = 16'h0000;
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start    = 1'b0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = 16'h0100;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_addr", ifc.w_addr, 32'd10);
    ifc.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst1");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst1_idle_valid", ifc.out_valid, 32'd0);
    run_case(vecs[0], 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
